// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM state
// encoding and frame/word geometry constants.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int FRAME_HDR_BYTES = 2;
  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_ADDR_SHIFT = 2;
  localparam int LANE_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_assembler.sv
// Packs stream bytes little-endian into a 32-bit word and keeps the running
// XOR checksum of every byte loaded since the last clear.
module byte_assembler
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  input  logic              load,
  output logic [31:0]       word,
  output logic [LANE_W-1:0] lane,
  output logic              word_full,
  output logic [7:0]        checksum
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lane <= '0;
    end else if (load) begin
      lane <= lane + LANE_W'(1);
    end
  end

  // Word and checksum are data: they only need clearing at the start of a load
  always_ff @(posedge clock) begin
    if (clear) begin
      word     <= '0;
      checksum <= '0;
    end else if (load) begin
      word[8*lane +: 8] <= byte_in;
      checksum          <= checksum ^ byte_in;
    end
  end

  // High on the load that completes the current word
  assign word_full = load && (lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Fills instruction memory from a framed byte stream (length, data, XOR
// checksum) and keeps the CPU held until a load completes with a good checksum.
module program_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int CNT_WIDTH = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 imem_write_en,
  output logic [31:0]          imem_write_addr,
  output logic [31:0]          imem_write_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] words_loaded
);

  state_t              state, state_nxt;
  logic [15:0]         len_q;
  logic [15:0]         len_full;
  logic                accept, clear, load;
  logic                word_full;
  logic [31:0]         asm_word;
  logic [7:0]          checksum;
  logic [LANE_W-1:0]   lane_unused;
  logic [31:0]         wr_addr;
  logic [31:0]         addr_hold, data_hold;

  assign byte_ready = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == DATA)   || (state == CHECK);
  assign accept     = byte_valid && byte_ready;
  assign clear      = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign load       = accept && (state == DATA);
  assign len_full   = {byte_in, len_q[7:0]};

  byte_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .byte_in   (byte_in),
    .load      (load),
    .word      (asm_word),
    .lane      (lane_unused),
    .word_full (word_full),
    .checksum  (checksum)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = LEN_LO;
      LEN_LO:            if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len_full > 16'(MAX_WORDS)) state_nxt = ERROR;
          else if (len_full == 16'd0)    state_nxt = CHECK;
          else                           state_nxt = DATA;
        end
      end
      DATA:              if (word_full) state_nxt = WRITE;
      WRITE:             state_nxt = (16'(words_loaded) + 16'd1 == len_q) ? CHECK : DATA;
      CHECK:             if (accept) state_nxt = (byte_in == checksum) ? DONE : ERROR;
      default:           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      words_loaded <= '0;
      addr_hold    <= '0;
      data_hold    <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        words_loaded <= '0;
      end else if (state == WRITE) begin
        words_loaded <= words_loaded + CNT_WIDTH'(1);
        addr_hold    <= wr_addr;
        data_hold    <= asm_word;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept && (state == LEN_LO)) len_q[7:0]  <= byte_in;
    if (accept && (state == LEN_HI)) len_q[15:8] <= byte_in;
  end

  // The write port shows the live word during WRITE and holds it afterwards
  assign wr_addr         = 32'(words_loaded) << WORD_ADDR_SHIFT;
  assign imem_write_en   = (state == WRITE);
  assign imem_write_addr = imem_write_en ? wr_addr  : addr_hold;
  assign imem_write_data = imem_write_en ? asm_word : data_hold;
  assign cpu_hold        = (state != DONE);
  assign done            = (state == DONE);
  assign error           = (state == ERROR);

endmodule
